// File: rtl/init_regfile_pkg.sv
// Shared types and helpers for the init_regfile register bank.
package init_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Address width for a bank of the given depth; one bit minimum keeps ports legal.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/init_sweep_ctrl.sv
// Sweep sequencer: walks ptr over every entry once per init_start and emits a write strobe.
module init_sweep_ctrl
    import init_regfile_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_start,
    input  logic [WIDTH-1:0] init_val,
    output logic             sweep_we,
    output logic [AW-1:0]    sweep_addr,
    output logic [WIDTH-1:0] sweep_data,
    output logic             busy,
    output logic             done
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state, state_nxt;
    logic [AW-1:0]    ptr, ptr_nxt;
    logic [WIDTH-1:0] sweep_val, sweep_val_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            sweep_val <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            sweep_val <= sweep_val_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        sweep_val_nxt = sweep_val;
        case (state)
            IDLE: begin
                if (init_start) begin
                    state_nxt     = SWEEP;
                    ptr_nxt       = '0;
                    sweep_val_nxt = init_val;
                end
            end
            SWEEP: begin
                // Stop on the last entry so ptr never steps past DEPTH-1.
                if (ptr == LAST) begin
                    state_nxt = DONE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

    assign sweep_we   = (state == SWEEP);
    assign sweep_addr = ptr;
    assign sweep_data = sweep_val;
    assign busy       = (state == SWEEP);
    assign done       = (state == DONE);

endmodule

// File: rtl/init_regfile.sv
// Register bank with one write port, one registered read port and a broadcast init sweep.
module init_regfile
    import init_regfile_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_start,
    input  logic [WIDTH-1:0] init_val,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             done,
    output logic             wr_err
);

    localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             sweep_we;
    logic [AW-1:0]    sweep_addr;
    logic [WIDTH-1:0] sweep_data;
    logic             waddr_ok;
    logic             raddr_ok;

    init_sweep_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .init_start (init_start),
        .init_val   (init_val),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .sweep_data (sweep_data),
        .busy       (busy),
        .done       (done)
    );

    // Addresses at or above DEPTH are only reachable when DEPTH is not a power of two.
    assign waddr_ok = ({1'b0, waddr} < DEPTH_EXT);
    assign raddr_ok = ({1'b0, raddr} < DEPTH_EXT);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata  <= '0;
            wr_err <= 1'b0;
        end else begin
            // Sweep owns the array while busy; external writes then get reported, not applied.
            if (sweep_we) begin
                mem[sweep_addr] <= sweep_data;
            end else if (wen && waddr_ok) begin
                mem[waddr] <= wdata;
            end
            wr_err <= busy && wen && waddr_ok;
            rdata  <= raddr_ok ? mem[raddr] : '0;
        end
    end

endmodule

// File: tb/tb_init_regfile.sv
// Scoreboard bench for init_regfile: DEPTH=8 and DEPTH=5 instances driven with directed vectors.
module tb_init_regfile;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: DEPTH=8
    logic       init_start_a, wen_a, busy_a, done_a, wr_err_a;
    logic [3:0] init_val_a, wdata_a, rdata_a;
    logic [2:0] waddr_a, raddr_a;
    // Instance B: DEPTH=5
    logic       init_start_b, wen_b, busy_b, done_b, wr_err_b;
    logic [3:0] init_val_b, wdata_b, rdata_b;
    logic [2:0] waddr_b, raddr_b;

    init_regfile #(.WIDTH(4), .DEPTH(8)) dut_a (
        .clk(clk), .rst(rst), .init_start(init_start_a), .init_val(init_val_a),
        .wen(wen_a), .waddr(waddr_a), .wdata(wdata_a), .raddr(raddr_a),
        .rdata(rdata_a), .busy(busy_a), .done(done_a), .wr_err(wr_err_a)
    );

    init_regfile #(.WIDTH(4), .DEPTH(5)) dut_b (
        .clk(clk), .rst(rst), .init_start(init_start_b), .init_val(init_val_b),
        .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b), .raddr(raddr_b),
        .rdata(rdata_b), .busy(busy_b), .done(done_b), .wr_err(wr_err_b)
    );

    localparam int RD_A = 0, BUSY_A = 1, DONE_A = 2, ERR_A = 3;
    localparam int RD_B = 4, BUSY_B = 5, DONE_B = 6, ERR_B = 7;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] exp;
        string      name;
    } item_t;

    item_t sb[$];
    int    cyc   = 0;
    int    tests = 0;
    int    fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(input int sig);
        case (sig)
            RD_A:    return {4'h0, rdata_a};
            BUSY_A:  return {7'h0, busy_a};
            DONE_A:  return {7'h0, done_a};
            ERR_A:   return {7'h0, wr_err_a};
            RD_B:    return {4'h0, rdata_b};
            BUSY_B:  return {7'h0, busy_b};
            DONE_B:  return {7'h0, done_b};
            default: return {7'h0, wr_err_b};
        endcase
    endfunction

    // Monitor: sample mid-cycle and retire every expectation due in this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [7:0] got;
                got = actual(sb[i].sig);
                tests++;
                if (got !== sb[i].exp) begin
                    fails++;
                    $display("FAIL %s @cyc %0d: got %0h expected %0h", sb[i].name, cyc, got, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic exp_at(input int sig, input logic [7:0] exp, input int dly, input string name);
        item_t it;
        it.cyc  = cyc + dly;
        it.sig  = sig;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected status timeline for a DEPTH-entry sweep requested in the current cycle.
    task automatic sweep_checks(input int busy_sig, input int done_sig, input int depth, input string tag);
        for (int d = 0; d <= depth + 2; d++) begin
            exp_at(busy_sig, (d >= 1 && d <= depth) ? 8'd1 : 8'd0, d, {tag, "_busy"});
            exp_at(done_sig, (d == depth + 1) ? 8'd1 : 8'd0, d, {tag, "_done"});
        end
    endtask

    task automatic rd_all_a(input logic [3:0] val, input string tag);
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i);
            exp_at(RD_A, {4'h0, val}, 1, tag);
            step();
        end
    endtask

    task automatic sweep_a(input logic [3:0] val, input string tag);
        init_start_a = 1'b1;
        init_val_a   = val;
        sweep_checks(BUSY_A, DONE_A, 8, tag);
        step();
        init_start_a = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        rst = 1'b1;
        init_start_a = 0; init_val_a = 0; wen_a = 0; waddr_a = 0; wdata_a = 0; raddr_a = 0;
        init_start_b = 0; init_val_b = 0; wen_b = 0; waddr_b = 0; wdata_b = 0; raddr_b = 0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        exp_at(BUSY_A, 0, 0, "rst_busy");
        exp_at(DONE_A, 0, 0, "rst_done");
        exp_at(ERR_A, 0, 0, "rst_wr_err");
        exp_at(RD_A, 0, 0, "rst_rdata");
        rd_all_a(4'h0, "rst_read");

        // Basic sweep
        sweep_a(4'hA, "sweepA");
        rd_all_a(4'hA, "sweepA_read");

        // Collision: IDLE write alongside start, then a dropped write during the sweep
        wen_a = 1; waddr_a = 3; wdata_a = 4'h5;
        init_start_a = 1; init_val_a = 4'hC;
        sweep_checks(BUSY_A, DONE_A, 8, "coll");
        exp_at(ERR_A, 0, 1, "coll_idle_wr_err");
        step();
        wen_a = 0; init_start_a = 0;
        step();
        wen_a = 1; waddr_a = 0; wdata_a = 4'h7;
        exp_at(ERR_A, 1, 1, "coll_wr_err_pulse");
        exp_at(ERR_A, 0, 2, "coll_wr_err_single");
        step();
        wen_a = 0;
        repeat (8) step();
        rd_all_a(4'hC, "coll_read");

        // Ignored restarts mid-sweep and in DONE; a DONE-state write still lands
        init_start_a = 1; init_val_a = 4'h3;
        sweep_checks(BUSY_A, DONE_A, 8, "restart");
        step();
        init_start_a = 0;
        repeat (3) step();
        init_start_a = 1; init_val_a = 4'hF;
        step();
        init_start_a = 0;
        repeat (4) step();
        init_start_a = 1; init_val_a = 4'hF;
        wen_a = 1; waddr_a = 2; wdata_a = 4'h9;
        exp_at(ERR_A, 0, 1, "done_write_no_err");
        for (int d = 2; d <= 4; d++) exp_at(BUSY_A, 0, d, "restart_no_busy");
        step();
        init_start_a = 0; wen_a = 0;
        repeat (4) step();
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i);
            exp_at(RD_A, (i == 2) ? 8'h9 : 8'h3, 1, "restart_read");
            step();
        end

        // Reset mid-sweep
        init_start_a = 1; init_val_a = 4'h6;
        for (int d = 1; d <= 4; d++) exp_at(BUSY_A, 1, d, "midrst_busy_pre");
        step();
        init_start_a = 0;
        repeat (3) step();
        rst = 1; raddr_a = 0;
        exp_at(RD_A, 0, 1, "midrst_rdata");
        for (int d = 1; d <= 9; d++) begin
            exp_at(BUSY_A, 0, d, "midrst_busy");
            exp_at(DONE_A, 0, d, "midrst_no_done");
        end
        step();
        rst = 0;
        repeat (6) step();
        rd_all_a(4'h0, "midrst_read");
        sweep_a(4'h5, "resweep");
        rd_all_a(4'h5, "resweep_read");

        // Non-power-of-two depth
        init_start_b = 1; init_val_b = 4'h9;
        sweep_checks(BUSY_B, DONE_B, 5, "d5");
        step();
        init_start_b = 0;
        step();
        wen_b = 1; waddr_b = 7; wdata_b = 4'h1;
        exp_at(ERR_B, 0, 1, "d5_oob_no_err");
        step();
        waddr_b = 4;
        exp_at(ERR_B, 1, 1, "d5_drop_err");
        step();
        wen_b = 0;
        repeat (4) step();
        for (int i = 0; i < 8; i++) begin
            raddr_b = 3'(i);
            exp_at(RD_B, (i < 5) ? 8'h9 : 8'h0, 1, "d5_read");
            step();
        end
        wen_b = 1; waddr_b = 7; wdata_b = 4'h1;
        exp_at(ERR_B, 0, 1, "d5_idle_oob_no_err");
        step();
        waddr_b = 1; wdata_b = 4'h2; raddr_b = 1;
        exp_at(RD_B, 8'h9, 1, "d5_no_bypass");
        step();
        wen_b = 0;
        exp_at(RD_B, 8'h2, 1, "d5_write_visible");
        step();
        raddr_b = 6;
        exp_at(RD_B, 8'h0, 1, "d5_raddr6");
        step();

        tests++;
        if (rdata_b !== 4'h0) begin
            fails++;
            $display("FAIL d5_raddr6_direct: got %0h expected 0", rdata_b);
        end
        tests++;
        if (busy_b !== 1'b0) begin
            fails++;
            $display("FAIL d5_idle_busy: got %0b expected 0", busy_b);
        end
        tests++;
        if (done_b !== 1'b0) begin
            fails++;
            $display("FAIL d5_idle_done: got %0b expected 0", done_b);
        end
        tests++;
        if (wr_err_b !== 1'b0) begin
            fails++;
            $display("FAIL d5_idle_wr_err: got %0b expected 0", wr_err_b);
        end
        tests++;
        if (busy_a !== 1'b0) begin
            fails++;
            $display("FAIL a_idle_busy: got %0b expected 0", busy_a);
        end

        repeat (3) step();

        foreach (sb[i]) begin
            tests++;
            fails++;
            $display("FAIL %s: never checked (due cyc %0d, now %0d)", sb[i].name, sb[i].cyc, cyc);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/init_regfile.md
# init_regfile

Parametrised register bank with a built-in initialisation sweep. It holds DEPTH entries of WIDTH bits. It provides one write port and one registered read port. A single start pulse makes it load a runtime value into every entry, one entry per cycle, with busy/done status. It replaces single-register loaders wherever several datapath registers must be preset to a common value before a computation pass.

## Interface
Parameters:
- WIDTH, 4, bits per entry
- DEPTH, 8, number of entries, ≥2, need not be a power of two
- AW, $clog2(DEPTH), address width (derived, do not override)

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  reset, synchronous and active-high
- init_start  in  1  one-cycle request to start a sweep
- init_val  in  WIDTH  value written to every entry by the sweep, sampled with init_start
- wen  in  1  external write enable
- waddr  in  AW  external write address
- wdata  in  WIDTH  external write data
- raddr  in  AW  read address
- rdata  out  WIDTH  registered read data
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse, sweep finished
- wr_err  out  1  one-cycle pulse, external write dropped

## Operation
- States: IDLE, SWEEP, DONE. The state is a register.
  - busy = (state==SWEEP)
  - done = (state==DONE)
- IDLE: init_start=1 moves to SWEEP.
  - ptr ← 0
  - init_val is latched into sweep_val
- SWEEP, each cycle:
  - mem[ptr] ← sweep_val
  - ptr ← ptr+1
  - when ptr==DEPTH-1 (last write), move to DONE
- DONE: always moves to IDLE after one cycle.
- init_start in SWEEP or DONE is ignored. It is not queued.
- External write, IDLE or DONE: if wen=1 and waddr<DEPTH, then mem[waddr] ← wdata.
- External write, SWEEP: wen=1 is dropped and wr_err=1 the next cycle. The entry is not modified.
- wen=1 with waddr≥DEPTH is ignored in every state and does not raise wr_err.
- wen and init_start in the same IDLE cycle: the external write commits at that edge. The sweep then overwrites it.
- Read: rdata ← mem[raddr] every cycle, in every state.
  - rdata ← 0 if raddr≥DEPTH
  - The read returns the pre-edge contents. There is no write-to-read bypass.
- Reset, including mid-sweep:
  - all entries = 0
  - rdata = 0
  - state = IDLE, so busy = 0 and done = 0
  - wr_err = 0
  - ptr = 0
  - sweep_val = 0
  - The interrupted sweep is abandoned and done is not pulsed.

## Timing
- init_start sampled at edge t gives busy=1 during cycles t+1 … t+DEPTH.
- Entry k is written at edge t+1+k.
- done=1 during cycle t+DEPTH+1. busy=0 in that cycle.
- The block is back in IDLE from cycle t+DEPTH+2.
- Earliest accepted restart: init_start present at edge t+DEPTH+2. Minimum sweep period is DEPTH+2 cycles.
- Read latency is 1 cycle: raddr at edge e gives rdata valid after e.
- A write at edge e is visible to a read sampled at edge e+1, so it appears on rdata after e+1.
- wr_err is registered: a dropped write at edge e gives wr_err high for the cycle after e.
- The ptr width is AW. Its last value is DEPTH-1, so no wrap past DEPTH occurs for non-power-of-two DEPTH.

## Structure
- Shared package init_regfile_pkg holds:
  - state enum (IDLE, SWEEP, DONE)
  - width helper function for AW
- Sub-module init_sweep_ctrl holds the FSM, ptr, sweep_val, busy and done.
  - It outputs a sweep write strobe, address and data to the top level.
  - The top level holds the storage array, write arbitration (sweep has priority), wr_err and the read register.

## Test plan
- Reset then read: rst high 2 cycles, read all addresses → rdata=0 for every entry; busy=done=wr_err=0.
- Basic sweep (WIDTH=4, DEPTH=8): init_start with init_val=4'hA at edge t → busy high exactly 8 cycles, done high at cycle t+9; all reads return 4'hA afterwards.
- Collision: in the IDLE cycle, wen (addr 3, data 4'h5) together with init_start (init_val=4'hC) → mem[3]=4'hC after sweep. During SWEEP, wen (addr 0, data 4'h7) → dropped, wr_err pulses once, mem[0]=4'hC.
- Ignored restart: init_start pulsed mid-sweep and during DONE → no extra sweep; busy falls on schedule.
- Reset mid-sweep: rst at sweep cycle 4 → all entries 0, busy=0, no done pulse; a new init_start then completes normally.
- Non-power-of-two (DEPTH=5): sweep takes 5 busy cycles; raddr=6 returns 0; wen to addr 7 is ignored with no wr_err.
